uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encoding, default frame parameters and a
//               2-of-3 majority helper, used by both uart_rx and uart_tx.
// Revision    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int c_DEFAULT_DATA_BITS  = 8;
    localparam int c_DEFAULT_STOP_BITS  = 1;
    localparam int c_DEFAULT_OVERSAMPLE = 16;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Receiver-to-FIFO write port plus status and error pulses.
// Revision    : 1.0
// ============================================================================
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = c_DEFAULT_DATA_BITS
) ();
    logic                 fifo_wr_en;
    logic [DATA_BITS-1:0] fifo_din;
    logic                 fifo_full;
    logic                 busy;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun_err;

    modport master (
        output fifo_wr_en, fifo_din, busy, frame_err, parity_err, overrun_err,
        input  fifo_full
    );

    modport slave (
        input  fifo_wr_en, fifo_din, busy, frame_err, parity_err, overrun_err,
        output fifo_full
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the serial line with a registered
//               falling-edge detect on the synchronized value.
// Revision    : 1.0
// ============================================================================
module uart_rx_sync (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  rx_line,
    output logic rx_sync,
    output logic fall_edge
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // All flops reset high so the idle line never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_sync   = r_sync;
    assign fall_edge = r_prev & ~r_sync;
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampled UART receiver with optional parity, frame/parity/
//               overrun detection and a one-cycle FIFO write strobe.
//               Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority bit vote.
// Revision    : 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = c_DEFAULT_DATA_BITS,
    parameter int STOP_BITS  = c_DEFAULT_STOP_BITS,
    parameter int OVERSAMPLE = c_DEFAULT_OVERSAMPLE
) (
    input  wire        clk,
    input  wire        rst_n,
    input  wire        os_tick,
    input  wire        rx_line,
    input  wire        parity_en,
    input  wire        parity_odd,
    uart_rx_if.master  fifo
);
    localparam int                 c_CNT_W     = $clog2(OVERSAMPLE);
    localparam logic [c_CNT_W-1:0] c_HALF_TICK = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_TICK = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]         c_LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic               c_LAST_STOP = 1'(STOP_BITS - 1);

    logic w_line;
    logic w_fall;
    logic w_bit;

    uart_state_t          r_state;
    logic [c_CNT_W-1:0]   r_tick_cnt;
    logic [3:0]           r_bit_cnt;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_par_acc;
    logic                 r_par_fail;
    logic                 r_frame_fail;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_line   (rx_line),
        .rx_sync   (w_line),
        .fall_edge (w_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // The window is the two preceding ticks plus the decision tick, so every
    // decision lands on the same tick as in the single-sample build.
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else if (os_tick) begin
            r_hist <= {r_hist[0], w_line};
        end
    end

    assign w_bit = maj3(r_hist[1], r_hist[0], w_line);
`else
    assign w_bit = w_line;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_tick_cnt       <= '0;
            r_bit_cnt        <= '0;
            r_stop_cnt       <= 1'b0;
            r_shift          <= '0;
            r_par_en         <= 1'b0;
            r_par_odd        <= 1'b0;
            r_par_acc        <= 1'b0;
            r_par_fail       <= 1'b0;
            r_frame_fail     <= 1'b0;
            fifo.fifo_din    <= '0;
            fifo.fifo_wr_en  <= 1'b0;
            fifo.busy        <= 1'b0;
            fifo.frame_err   <= 1'b0;
            fifo.parity_err  <= 1'b0;
            fifo.overrun_err <= 1'b0;
        end else begin
            fifo.fifo_wr_en  <= 1'b0;
            fifo.frame_err   <= 1'b0;
            fifo.parity_err  <= 1'b0;
            fifo.overrun_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_tick_cnt <= '0;
                    if (w_fall) begin
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (os_tick) begin
                        if (r_tick_cnt == c_HALF_TICK) begin
                            r_tick_cnt <= '0;
                            if (!w_bit) begin
                                r_state      <= ST_DATA;
                                fifo.busy    <= 1'b1;
                                r_par_en     <= parity_en;
                                r_par_odd    <= parity_odd;
                                r_bit_cnt    <= '0;
                                r_stop_cnt   <= 1'b0;
                                r_par_acc    <= 1'b0;
                                r_par_fail   <= 1'b0;
                                r_frame_fail <= 1'b0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (os_tick) begin
                        if (r_tick_cnt == c_FULL_TICK) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {w_bit, r_shift[DATA_BITS-1:1]};
                            r_par_acc  <= r_par_acc ^ w_bit;
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_state <= r_par_en ? ST_PARITY : ST_STOP;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (os_tick) begin
                        if (r_tick_cnt == c_FULL_TICK) begin
                            r_tick_cnt <= '0;
                            r_state    <= ST_STOP;
                            if (w_bit != (r_par_acc ^ r_par_odd)) begin
                                r_par_fail <= 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (os_tick) begin
                        if (r_tick_cnt == c_FULL_TICK) begin
                            r_tick_cnt <= '0;
                            if (r_stop_cnt == c_LAST_STOP) begin
                                // Final stop sample: resolve the frame in priority order.
                                r_state   <= ST_IDLE;
                                fifo.busy <= 1'b0;
                                if (r_frame_fail || !w_bit) begin
                                    fifo.frame_err <= 1'b1;
                                end else if (r_par_fail) begin
                                    fifo.parity_err <= 1'b1;
                                end else if (fifo.fifo_full) begin
                                    fifo.overrun_err <= 1'b1;
                                end else begin
                                    fifo.fifo_wr_en <= 1'b1;
                                    fifo.fifo_din   <= r_shift;
                                end
                            end else begin
                                r_stop_cnt <= r_stop_cnt + 1'b1;
                                if (!w_bit) begin
                                    r_frame_fail <= 1'b1;
                                end
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    fifo.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Scoreboard bench for uart_rx (8 data bits, 1 stop, x16 ticks).
// Revision    : 1.0
// ============================================================================
module tb_uart_rx;
    localparam int TICK_DIV = 3;
    localparam logic [1:0] K_WR = 2'd0, K_FE = 2'd1, K_PE = 2'd2, K_OV = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, os_tick = 1'b0, rx_line = 1'b1;
    logic parity_en = 1'b0, parity_odd = 1'b0;
    int   tdiv = 0;
    int   vectors = 0, miscompares = 0;
    logic mid_busy;
    exp_t sb[$];

    uart_rx_if #(.DATA_BITS(8)) fifo_if ();

    uart_rx #(.DATA_BITS(8), .STOP_BITS(1), .OVERSAMPLE(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .os_tick    (os_tick),
        .rx_line    (rx_line),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .fifo       (fifo_if.master)
    );

    always #5 clk = ~clk;

    // os_tick every TICK_DIV clocks, leaving idle cycles between ticks.
    always @(posedge clk) begin
        if (tdiv == TICK_DIV - 1) begin
            tdiv    <= 0;
            os_tick <= 1'b1;
        end else begin
            tdiv    <= tdiv + 1;
            os_tick <= 1'b0;
        end
    end

    always @(negedge clk) begin : monitor
        int         n;
        exp_t       e;
        logic [1:0] k;
        n = int'(fifo_if.fifo_wr_en) + int'(fifo_if.frame_err) +
            int'(fifo_if.parity_err) + int'(fifo_if.overrun_err);
        if (n != 0) begin
            vectors++;
            k = fifo_if.frame_err ? K_FE : fifo_if.parity_err ? K_PE :
                fifo_if.overrun_err ? K_OV : K_WR;
            if (n > 1) begin
                miscompares++;
                $display("FAIL pulse_count: got %0d simultaneous pulses, expected 1", n);
            end else if (fifo_if.fifo_wr_en && fifo_if.fifo_full) begin
                miscompares++;
                $display("FAIL wr_while_full: got fifo_wr_en=1 with fifo_full=1");
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got kind %0d din %02h, expected nothing",
                         k, fifo_if.fifo_din);
            end else begin
                e = sb.pop_front();
                if (e.kind !== k || (k == K_WR && fifo_if.fifo_din !== e.data)) begin
                    miscompares++;
                    $display("FAIL output: got kind %0d din %02h, expected kind %0d din %02h",
                             k, fifo_if.fifo_din, e.kind, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [1:0] k, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        sb.push_back(e);
    endfunction

    task automatic hold(input int ticks);
        repeat (ticks * TICK_DIV) @(negedge clk);
    endtask

    // par/pv: parity bit present and its value; sv: stop bit value;
    // rst_bit/spike_bit: data bit index for a reset pulse / one-tick spike (-1 none).
    task automatic send_frame(input logic [7:0] d, input bit par, input bit pv, input bit sv,
                              input int rst_bit, input int spike_bit, input int idle_ticks);
        rx_line = 1'b0;
        hold(16);
        mid_busy = fifo_if.busy;
        for (int i = 0; i < 8; i++) begin
            rx_line = d[i];
            if (i == rst_bit) begin
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                check("busy_after_reset", 32'(fifo_if.busy), 32'd0);
            end
            if (i == spike_bit) begin
                hold(7);
                rx_line = ~d[i];
                hold(1);
                rx_line = d[i];
                hold(8);
            end else begin
                hold(16);
            end
        end
        if (par) begin
            rx_line = pv;
            hold(16);
        end
        rx_line = sv;
        hold(16);
        rx_line = 1'b1;
        hold(idle_ticks);
    endtask

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    end

    initial begin : stimulus
        logic seen_busy;
        fifo_if.fifo_full = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_flags", {28'd0, fifo_if.busy, fifo_if.fifo_wr_en, fifo_if.frame_err,
              fifo_if.parity_err | fifo_if.overrun_err}, 32'd0);
        check("reset_din", 32'(fifo_if.fifo_din), 32'd0);
        rst_n = 1'b1;
        hold(4);

        push(K_WR, 8'hA5);
        send_frame(8'hA5, 0, 0, 1, -1, -1, 4);
        check("busy_mid_A5", 32'(mid_busy), 32'd1);
        check("busy_after_A5", 32'(fifo_if.busy), 32'd0);

        seen_busy = 1'b0;
        rx_line = 1'b0;
        for (int i = 0; i < 4 * TICK_DIV; i++) begin
            @(negedge clk);
            seen_busy |= fifo_if.busy;
        end
        rx_line = 1'b1;
        for (int i = 0; i < 30 * TICK_DIV; i++) begin
            @(negedge clk);
            seen_busy |= fifo_if.busy;
        end
        check("glitch_busy", 32'(seen_busy), 32'd0);

        parity_en  = 1'b1;
        parity_odd = 1'b0;
        push(K_WR, 8'h3C);
        send_frame(8'h3C, 1, 0, 1, -1, -1, 4);
        push(K_PE, 8'h00);
        send_frame(8'h3C, 1, 1, 1, -1, -1, 4);
        parity_odd = 1'b1;
        push(K_WR, 8'h3C);
        send_frame(8'h3C, 1, 1, 1, -1, -1, 4);
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        push(K_FE, 8'h00);
        send_frame(8'h55, 0, 0, 0, -1, -1, 4);
        check("busy_after_ferr", 32'(fifo_if.busy), 32'd0);
        push(K_WR, 8'h12);
        send_frame(8'h12, 0, 0, 1, -1, -1, 4);

        fifo_if.fifo_full = 1'b1;
        push(K_OV, 8'h00);
        send_frame(8'h7E, 0, 0, 1, -1, -1, 0);
        fifo_if.fifo_full = 1'b0;
        hold(4);
        push(K_WR, 8'h01);
        push(K_WR, 8'h02);
        send_frame(8'h01, 0, 0, 1, -1, -1, 0);
        send_frame(8'h02, 0, 0, 1, -1, -1, 4);

        send_frame(8'hFF, 0, 0, 1, 3, -1, 4);
        push(K_WR, 8'h81);
        send_frame(8'h81, 0, 0, 1, -1, -1, 4);
        check("din_after_81", 32'(fifo_if.fifo_din), 32'h81);

`ifdef UART_RX_MAJORITY_EN
        push(K_WR, 8'h5A);
        send_frame(8'h5A, 0, 0, 1, -1, 1, 4);
`endif

        hold(20);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("busy_final", 32'(fifo_if.busy), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
